// File: rtl/bcd_pkg.sv
// Shared BCD types, constants and helpers for the stopwatch datapath.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } cd_state_t;

  // True when every nibble of a packed 4-digit value is a legal BCD digit.
  function automatic logic bcd_valid16(input logic [15:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (v[i*4 +: 4] > BCD_MAX) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of the decrement borrow chain (mirror of the adder carry cell).
module bcd_digit_dec
  import bcd_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       bin,
  output bcd_digit_t dout,
  output logic       bout
);

  // Subtract the incoming borrow; a zero digit with a borrow wraps to nine.
  always_comb begin
    dout = digit;
    bout = 1'b0;
    if (digit >= {3'b000, bin}) begin
      dout = digit - {3'b000, bin};
      bout = 1'b0;
    end else begin
      dout = BCD_MAX;
      bout = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_countdown16.sv
// Four-digit BCD countdown timer: load/start/stop control, ripple borrow
// decrement on prescaler ticks, expiry and rejected-load pulses.
module bcd_countdown16
  import bcd_pkg::*;
#(
  parameter bit HOLD_AT_ZERO = 1'b1
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        start,
  input  logic        stop,
  output logic [15:0] count,
  output logic        running,
  output logic        done,
  output logic        expired,
  output logic        invalid_load
);

  cd_state_t   r_state;
  logic [15:0] r_count;
  logic        r_running;
  logic        r_done;
  logic        r_expired;
  logic        r_invalid;

  cd_state_t   w_state_nxt;
  logic [15:0] w_count_nxt;
  logic        w_expired_nxt;
  logic        w_invalid_nxt;
  logic [15:0] w_dec;
  logic [4:0]  w_borrow;
  logic        w_zero;
  logic        w_start_ok;
  logic        w_load_ok;

  // Least significant digit always borrows one; each stage feeds the next.
  assign w_borrow[0] = 1'b1;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dec
      bcd_digit_dec u_dec (
        .digit (r_count[g*4 +: 4]),
        .bin   (w_borrow[g]),
        .dout  (w_dec[g*4 +: 4]),
        .bout  (w_borrow[g+1])
      );
    end
  endgenerate

  assign w_zero     = (r_count == 16'h0000);
  assign w_load_ok  = bcd_valid16(load_val);
  // Starting from zero only makes sense when the counter is allowed to wrap.
  assign w_start_ok = start && (!w_zero || (HOLD_AT_ZERO == 1'b0));

  // Next-state, next-count and pulse decode with load > stop > start > tick.
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_expired_nxt = 1'b0;
    w_invalid_nxt = 1'b0;
    if (load) begin
      if (w_load_ok) begin
        w_count_nxt = load_val;
        w_state_nxt = IDLE;
      end else begin
        w_invalid_nxt = 1'b1;
      end
    end else begin
      case (r_state)
        IDLE, PAUSE: begin
          if (stop) begin
            w_state_nxt = r_state;
          end else if (w_start_ok) begin
            w_state_nxt = RUN;
          end else begin
            w_state_nxt = r_state;
          end
        end
        RUN: begin
          if (stop) begin
            w_state_nxt = PAUSE;
          end else if (tick) begin
            if (w_borrow[4] && HOLD_AT_ZERO) begin
              // Defensive: never wrap while holding; park at zero instead.
              w_count_nxt = 16'h0000;
              w_state_nxt = DONE;
            end else begin
              w_count_nxt = w_dec;
              if (w_dec == 16'h0000) begin
                w_expired_nxt = 1'b1;
                w_state_nxt   = HOLD_AT_ZERO ? DONE : RUN;
              end else begin
                w_state_nxt = RUN;
              end
            end
          end else begin
            w_state_nxt = RUN;
          end
        end
        DONE: begin
          w_count_nxt = 16'h0000;
          w_state_nxt = DONE;
        end
        default: begin
          w_count_nxt = 16'h0000;
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // State, count and registered status flags; reset also drops any pending pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_count   <= 16'h0000;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_expired <= 1'b0;
      r_invalid <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_running <= (w_state_nxt == RUN);
      r_done    <= (w_state_nxt == DONE);
      r_expired <= w_expired_nxt;
      r_invalid <= w_invalid_nxt;
    end
  end

  assign count        = r_count;
  assign running      = r_running;
  assign done         = r_done;
  assign expired      = r_expired;
  assign invalid_load = r_invalid;

endmodule

// File: tb/tb_bcd_countdown16.sv
// Bench for bcd_countdown16: a holding and a wrapping instance share one
// stimulus stream; an integer-valued model predicts both every cycle and a
// set of literal expectations pins the model itself.
module tb_bcd_countdown16;

  logic        clk;
  logic        rst_n;
  logic        tick;
  logic        load;
  logic [15:0] load_val;
  logic        start;
  logic        stop;

  logic [15:0] h_count, w_count;
  logic        h_running, w_running;
  logic        h_done, w_done;
  logic        h_expired, w_expired;
  logic        h_invalid, w_invalid;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  // Model: index 0 holds at zero, index 1 wraps.
  int m_val [2];
  int m_st  [2];
  bit m_exp [2];
  bit m_inv [2];

  bcd_countdown16 #(.HOLD_AT_ZERO(1'b1)) dut_h (
    .clk(clk), .rst_n(rst_n), .tick(tick), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .count(h_count), .running(h_running),
    .done(h_done), .expired(h_expired), .invalid_load(h_invalid)
  );

  bcd_countdown16 #(.HOLD_AT_ZERO(1'b0)) dut_w (
    .clk(clk), .rst_n(rst_n), .tick(tick), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .count(w_count), .running(w_running),
    .done(w_done), .expired(w_expired), .invalid_load(w_invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int from_bcd(input logic [15:0] b);
    return 1000 * int'(b[15:12]) + 100 * int'(b[11:8]) + 10 * int'(b[7:4]) + int'(b[3:0]);
  endfunction

  function automatic bit legal_bcd(input logic [15:0] b);
    bit ok = 1'b1;
    for (int i = 0; i < 4; i++) if (b[i*4 +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Model update on the active edge from the sampled inputs.
  always @(posedge clk) begin
    for (int h = 0; h < 2; h++) begin
      bit hold;
      hold = (h == 0);
      m_exp[h] = 1'b0;
      m_inv[h] = 1'b0;
      if (!rst_n) begin
        m_val[h] = 0;
        m_st[h]  = M_IDLE;
      end else if (load) begin
        if (legal_bcd(load_val)) begin
          m_val[h] = from_bcd(load_val);
          m_st[h]  = M_IDLE;
        end else begin
          m_inv[h] = 1'b1;
        end
      end else if (m_st[h] == M_IDLE || m_st[h] == M_PAUSE) begin
        if (!stop && start && (m_val[h] != 0 || !hold)) m_st[h] = M_RUN;
      end else if (m_st[h] == M_RUN) begin
        if (stop) m_st[h] = M_PAUSE;
        else if (tick) begin
          m_val[h] = (m_val[h] == 0) ? 9999 : m_val[h] - 1;
          if (m_val[h] == 0) begin
            m_exp[h] = 1'b1;
            if (hold) m_st[h] = M_DONE;
          end
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("hold_cycle", {h_count, h_running, h_done, h_expired, h_invalid},
            {to_bcd(m_val[0]), m_st[0] == M_RUN, m_st[0] == M_DONE, m_exp[0], m_inv[0]});
      check("wrap_cycle", {w_count, w_running, w_done, w_expired, w_invalid},
            {to_bcd(m_val[1]), m_st[1] == M_RUN, m_st[1] == M_DONE, m_exp[1], m_inv[1]});
    end
  end

  // Apply one cycle of inputs, then return 1 time unit after the edge.
  task automatic step(input logic t, input logic l, input logic [15:0] lv,
                      input logic s, input logic p, input logic r = 1'b1);
    @(negedge clk);
    tick = t; load = l; load_val = lv; start = s; stop = p; rst_n = r;
    @(posedge clk);
    #1;
    tick = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; rst_n = 1'b1;
  endtask

  // {count, running, done, expired, invalid_load}
  function automatic logic [19:0] hv();
    return {h_count, h_running, h_done, h_expired, h_invalid};
  endfunction
  function automatic logic [19:0] wv();
    return {w_count, w_running, w_done, w_expired, w_invalid};
  endfunction

  initial begin
    rst_n = 1'b0; tick = 1'b0; load = 1'b0; load_val = 16'h0000;
    start = 1'b0; stop = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    check("reset_h", hv(), {16'h0000, 4'b0000});
    check("reset_w", wv(), {16'h0000, 4'b0000});

    // Start at zero: holding instance ignores it, wrapping one runs.
    step(0, 0, 16'h0000, 1, 0);
    check("start0_h", hv(), {16'h0000, 4'b0000});
    check("start0_w", wv(), {16'h0000, 4'b1000});
    step(1, 0, 16'h0000, 0, 0);
    check("wrap_from0", wv(), {16'h9999, 4'b1000});

    // 0102 counting through a multi-digit borrow.
    step(0, 1, 16'h0102, 0, 0);
    step(0, 0, 16'h0000, 1, 0);
    check("run_0102", hv(), {16'h0102, 4'b1000});
    step(1, 0, 16'h0000, 0, 0);
    check("t1_0101", hv(), {16'h0101, 4'b1000});
    step(1, 0, 16'h0000, 0, 0);
    check("t2_0100", hv(), {16'h0100, 4'b1000});
    step(1, 0, 16'h0000, 0, 0);
    check("t3_0099", hv(), {16'h0099, 4'b1000});
    check("t3_0099_w", wv(), {16'h0099, 4'b1000});

    // 0002 to expiry.
    step(0, 1, 16'h0002, 0, 0);
    step(0, 0, 16'h0000, 1, 0);
    step(1, 0, 16'h0000, 0, 0);
    check("t_0001", hv(), {16'h0001, 4'b1000});
    step(1, 0, 16'h0000, 0, 0);
    check("expire_h", hv(), {16'h0000, 4'b0110});
    check("expire_w", wv(), {16'h0000, 4'b1010});
    step(1, 0, 16'h0000, 0, 0);
    check("done_hold", hv(), {16'h0000, 4'b0100});
    check("wrap_9999", wv(), {16'h9999, 4'b1000});
    step(0, 0, 16'h0000, 1, 0);
    check("done_start", hv(), {16'h0000, 4'b0100});

    // Wrap pass from 0001.
    step(0, 1, 16'h0001, 0, 0);
    check("load_clr_done", hv(), {16'h0001, 4'b0000});
    step(0, 0, 16'h0000, 1, 0);
    step(1, 0, 16'h0000, 0, 0);
    check("w_0000", wv(), {16'h0000, 4'b1010});
    step(1, 0, 16'h0000, 0, 0);
    check("w_9999", wv(), {16'h9999, 4'b1000});

    // Rejected load, then tick in IDLE.
    step(0, 1, 16'h12A4, 0, 0);
    check("bad_load_h", hv(), {16'h0000, 4'b0101});
    check("bad_load_w", wv(), {16'h9999, 4'b1001});
    step(0, 0, 16'h0000, 0, 0);
    check("inv_one_cycle", wv(), {16'h9999, 4'b1000});
    step(0, 1, 16'h1000, 0, 0);
    step(1, 0, 16'h0000, 0, 0);
    check("idle_tick", hv(), {16'h1000, 4'b0000});

    // Stop+start in IDLE stays IDLE.
    step(0, 0, 16'h0000, 1, 1);
    check("idle_stop_start", hv(), {16'h1000, 4'b0000});

    // Stop/start against tick at 0500.
    step(0, 1, 16'h0500, 0, 0);
    step(0, 0, 16'h0000, 1, 0);
    step(1, 0, 16'h0000, 0, 1);
    check("stop_tick", hv(), {16'h0500, 4'b0000});
    step(1, 0, 16'h0000, 0, 0);
    check("pause_tick", hv(), {16'h0500, 4'b0000});
    step(1, 0, 16'h0000, 1, 0);
    check("start_tick", hv(), {16'h0500, 4'b1000});
    step(1, 0, 16'h0000, 0, 0);
    check("t_0499", hv(), {16'h0499, 4'b1000});

    // Load beats tick while running.
    step(0, 1, 16'h0003, 0, 0);
    step(0, 0, 16'h0000, 1, 0);
    step(1, 1, 16'h0042, 0, 0);
    check("load_tick", hv(), {16'h0042, 4'b0000});

    // Reset mid-run, including one that lands on an expiring tick.
    step(0, 0, 16'h0000, 1, 0);
    step(1, 0, 16'h0000, 0, 0);
    step(0, 0, 16'h0000, 0, 0, 1'b0);
    check("rst_mid_h", hv(), {16'h0000, 4'b0000});
    check("rst_mid_w", wv(), {16'h0000, 4'b0000});
    step(0, 1, 16'h0001, 0, 0);
    step(0, 0, 16'h0000, 1, 0);
    step(1, 0, 16'h0000, 0, 0, 1'b0);
    check("rst_supp_exp", hv(), {16'h0000, 4'b0000});
    step(0, 0, 16'h0000, 0, 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
